fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer for the RV32 core. It owns the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction plus its PC into a one-entry fetch slot toward decode using a valid/ready handshake. It also handles branch/jump redirects, halt and resume, and back-pressure stalls, and keeps two performance counters.

## Interface
Parameters:
- PC_W, 32, width of the word-granular PC; also the width of the memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk1  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- imem_addr  out  PC_W  word address to the instruction memory; equals the PC register.
- imem_rdata  in  32  instruction word; combinational read of `imem_addr`.
- redirect_valid  in  1  redirect request from execute (branch taken, jump, resume).
- redirect_pc  in  PC_W  target word address; sampled only when `redirect_valid`=1.
- halt  in  1  stop-fetch request (ebreak/debug); sampled in RUN only.
- dec_valid  out  1  fetch slot holds a valid instruction.
- dec_ready  in  1  decode accepts the slot this cycle.
- dec_instr  out  32  registered instruction.
- dec_pc  out  PC_W  PC of `dec_instr`.
- state_o  out  2  FSM state: IDLE=0, RUN=1, HALT=2 (3 is unused).
- fetch_cnt  out  32  count of instructions captured into the slot.
- stall_cnt  out  32  count of back-pressure cycles.

## Operation
- Reset (async): pc=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, fetch_cnt=0, stall_cnt=0, state=IDLE.
- Transfer: a transfer happens on a cycle with `dec_valid` && `dec_ready`.
- Slot free: the slot is free when `!dec_valid` || `dec_ready`.
- Fetch: a fetch happens when state=RUN, the slot is free, there is no redirect and there is no halt. On the edge:
  - dec_instr <= imem_rdata
  - dec_pc <= pc
  - dec_valid <= 1
  - pc <= pc+1, mod 2^PC_W (0xFFFFFFFF wraps to 0)
  - fetch_cnt += 1
- Slot drain: on a transfer with no fetch and no redirect, dec_valid <= 0.
- Stall: on a cycle with `dec_valid` && `!dec_ready` && `!redirect_valid`:
  - pc and the slot hold.
  - stall_cnt += 1.
- Redirect (any state, highest priority):
  - pc <= redirect_pc, dec_valid <= 0 (the in-flight slot is killed even if `dec_ready`=1).
  - No fetch that cycle; state <= RUN.
- FSM:
  - IDLE -> RUN after one cycle unconditionally; no fetch occurs in IDLE.
  - RUN -> HALT when `halt`=1 and there is no redirect. No fetch that cycle, and pc holds. A valid slot is kept and drains through the normal handshake.
  - HALT: no fetches. The only exit is a redirect (-> RUN), or reset.
- Priority on simultaneous events: rst > redirect > halt > stall/fetch.
- Counters wrap modulo 2^32 and are not saturating.

## Timing
- Fetch latency: 1 cycle, from the edge at which the PC is presented to `dec_valid`/`dec_instr` being visible.
- Throughput: 1 instruction/cycle while `dec_ready`=1.
- Redirect penalty: the redirect edge clears the slot, and the target instruction is valid one edge later, giving exactly 1 bubble cycle.
- After reset release: first edge IDLE->RUN, second edge captures RESET_PC, third edge captures RESET_PC+1.
- `imem_addr`, `state_o`, `dec_*` and the counters are register outputs; there are no combinational input-to-output paths.
- `halt` asserted while `dec_valid`=1 and `dec_ready`=0: the slot stays valid in HALT until accepted.

## Structure
- Package `fetch_pkg`:
  - state encodings IDLE/RUN/HALT (2-bit)
  - NOP/reset instruction constant 32'h0
  - counter width 32
- Sub-module `fetch_perf_cnt`: the two wrapping counters with increment enables and async reset. The top level holds the FSM, PC and slot.

## Test plan
- Reset release, RESET_PC=0, imem[i]=i+0x100, `dec_ready`=1:
  - state 0->1 at edge 1
  - dec_pc=0, dec_instr=0x100 valid after edge 2
  - dec_pc=1 after edge 3
  - fetch_cnt=N after N fetches
- Stall: hold `dec_ready`=0 for 3 cycles with dec_pc=5 valid -> dec_pc/dec_instr unchanged, imem_addr=6, stall_cnt+=3. Release -> dec_pc=6 on the next edge.
- Redirect with `redirect_pc`=0x40 while dec_pc=7 valid and `dec_ready`=0:
  - next edge: dec_valid=0, imem_addr=0x40
  - following edge: dec_pc=0x40
  - no stall_cnt increment on the redirect cycle
- Halt with dec_pc=9 valid and `dec_ready`=0 -> state=2, pc frozen at 10, slot stays valid. Assert `dec_ready` -> dec_valid=0 with no new fetch. Redirect to 0x20 -> state=1, dec_pc=0x20 one edge later.
- Simultaneous `halt` and `redirect_valid` in RUN -> state stays RUN, pc=redirect_pc. PC=0xFFFFFFFF fetch -> next dec_pc=0.
- Async reset asserted mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int unsigned CNT_W     = 32;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch and stall performance counters; both wrap modulo 2^CNT_W.
import fetch_pkg::*;

module fetch_perf_cnt (
    input  logic             clk1,
    input  logic             rst,
    input  logic             fetch_inc,
    input  logic             stall_inc,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_inc) fetch_cnt <= fetch_cnt + 1'b1;
            if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC, one-entry fetch slot toward decode,
// redirect/halt FSM and performance counters.
import fetch_pkg::*;

module fetch_ctrl #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk1,
    input  logic             rst,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             halt,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [31:0]      dec_instr,
    output logic [PC_W-1:0]  dec_pc,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc;
    logic            slot_free;
    logic            fetch;
    logic            stall;

    assign slot_free = !dec_valid || dec_ready;
    assign fetch     = (state == RUN) && slot_free
                       && !redirect_valid && !halt;
    assign stall     = dec_valid && !dec_ready && !redirect_valid;

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = RUN;
        end else begin
            unique case (state)
                IDLE:    state_nxt = RUN;
                RUN:     if (halt) state_nxt = HALT;
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Redirect kills the slot even when decode is accepting it.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            dec_valid <= 1'b0;
            dec_instr <= NOP_INSTR;
            dec_pc    <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            dec_valid <= 1'b0;
        end else if (fetch) begin
            pc        <= pc + 1'b1;
            dec_valid <= 1'b1;
            dec_instr <= imem_rdata;
            dec_pc    <= pc;
        end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

    fetch_perf_cnt u_perf (
        .clk1      (clk1),
        .rst       (rst),
        .fetch_inc (fetch),
        .stall_inc (stall),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );

    assign imem_addr = pc;
    assign state_o   = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        halt           = 1'b0;
    logic        dec_valid;
    logic        dec_ready      = 1'b1;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [1:0]  state_o;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    // Memory model: word i holds i + 0x100.
    assign imem_rdata = imem_addr + 32'h100;

    fetch_ctrl #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk1           (clk1),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .state_o        (state_o),
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v,
                            input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'b0, dec_valid}, {31'b0, v});
        chk({tag, "_pc"}, dec_pc, pc);
        chk({tag, "_instr"}, dec_instr, ins);
    endtask

    initial begin
        #12;
        chk("rst_state", {30'b0, state_o}, 32'd0);
        chk_slot("rst", 1'b0, 32'h0, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_fcnt", fetch_cnt, 32'h0);
        chk("rst_scnt", stall_cnt, 32'h0);
        rst = 1'b0;

        step();
        chk("e1_state", {30'b0, state_o}, 32'd1);
        chk("e1_valid", {31'b0, dec_valid}, 32'd0);
        chk("e1_addr", imem_addr, 32'h0);
        step();
        chk_slot("e2", 1'b1, 32'h0, 32'h100);
        chk("e2_fcnt", fetch_cnt, 32'd1);
        step();
        chk_slot("e3", 1'b1, 32'h1, 32'h101);
        for (int i = 0; i < 4; i++) step();
        chk_slot("e7", 1'b1, 32'h5, 32'h105);
        chk("e7_addr", imem_addr, 32'h6);
        chk("e7_fcnt", fetch_cnt, 32'd6);

        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_slot("stall", 1'b1, 32'h5, 32'h105);
        chk("stall_addr", imem_addr, 32'h6);
        chk("stall_scnt", stall_cnt, 32'd3);
        chk("stall_fcnt", fetch_cnt, 32'd6);
        dec_ready = 1'b1;
        step();
        chk_slot("rel", 1'b1, 32'h6, 32'h106);
        step();
        chk_slot("pre_redir", 1'b1, 32'h7, 32'h107);

        dec_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("redir_valid", {31'b0, dec_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_scnt", stall_cnt, 32'd3);
        chk("redir_fcnt", fetch_cnt, 32'd8);
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        step();
        chk_slot("redir_tgt", 1'b1, 32'h40, 32'h140);
        chk("redir_tgt_addr", imem_addr, 32'h41);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h9;
        step();
        redirect_valid = 1'b0;
        step();
        chk_slot("pre_halt", 1'b1, 32'h9, 32'h109);
        chk("pre_halt_addr", imem_addr, 32'ha);

        dec_ready = 1'b0;
        halt      = 1'b1;
        step();
        chk("halt_state", {30'b0, state_o}, 32'd2);
        chk("halt_addr", imem_addr, 32'ha);
        chk_slot("halt", 1'b1, 32'h9, 32'h109);
        halt = 1'b0;
        step();
        chk("halt2_state", {30'b0, state_o}, 32'd2);
        chk("halt2_valid", {31'b0, dec_valid}, 32'd1);
        chk("halt2_scnt", stall_cnt, 32'd5);
        dec_ready = 1'b1;
        step();
        chk("drain_valid", {31'b0, dec_valid}, 32'd0);
        chk("drain_addr", imem_addr, 32'ha);
        step();
        chk("hold_valid", {31'b0, dec_valid}, 32'd0);
        chk("hold_fcnt", fetch_cnt, 32'd10);
        chk("hold_state", {30'b0, state_o}, 32'd2);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        chk("resume_state", {30'b0, state_o}, 32'd1);
        chk("resume_valid", {31'b0, dec_valid}, 32'd0);
        chk("resume_addr", imem_addr, 32'h20);
        redirect_valid = 1'b0;
        step();
        chk_slot("resume_tgt", 1'b1, 32'h20, 32'h120);
        chk("resume_fcnt", fetch_cnt, 32'd11);

        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_ffff;
        step();
        chk("both_state", {30'b0, state_o}, 32'd1);
        chk("both_addr", imem_addr, 32'hffff_ffff);
        chk("both_valid", {31'b0, dec_valid}, 32'd0);
        halt           = 1'b0;
        redirect_valid = 1'b0;
        step();
        chk_slot("top", 1'b1, 32'hffff_ffff, 32'h0000_00ff);
        chk("wrap_addr", imem_addr, 32'h0);
        step();
        chk_slot("wrap", 1'b1, 32'h0, 32'h100);
        chk("wrap_fcnt", fetch_cnt, 32'd13);

        dec_ready = 1'b0;
        step();
        chk("mid_scnt", stall_cnt, 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", {30'b0, state_o}, 32'd0);
        chk_slot("arst", 1'b0, 32'h0, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_fcnt", fetch_cnt, 32'h0);
        chk("arst_scnt", stall_cnt, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
